stream_to_video: RTL

- Receives the valid-qualified pixel stream produced by the scaler (dOut/dOutValid/nextDout side) and re-times it onto a fixed raster with continuous hs/vs/de timing for the display/HDMI encoder.
- Buffers pixels in a small internal FIFO and applies backpressure through nextDin.
- Issues a per-frame start pulse that restarts the upstream scaler, keeping frames aligned.
- Sits in the post_clk domain directly after the scaler.

---
 rtl/stream_to_video_pkg.sv | 28 ++
 rtl/stream_to_video_if.sv | 26 ++
 rtl/stream_to_video_sync_fifo_fwft.sv | 57 +++++
 rtl/stream_to_video.sv | 129 ++++++++++++
 4 files changed

// File: rtl/stream_to_video_pkg.sv
// Shared video timing defaults, controller state encoding and raster helpers
// for the stream_to_video block.
package stream_to_video_pkg;

    localparam int unsigned H_ACTIVE_DEF  = 1280;
    localparam int unsigned H_FP_DEF      = 110;
    localparam int unsigned H_SYNC_DEF    = 40;
    localparam int unsigned H_BP_DEF      = 220;
    localparam int unsigned V_ACTIVE_DEF  = 720;
    localparam int unsigned V_FP_DEF      = 5;
    localparam int unsigned V_SYNC_DEF    = 5;
    localparam int unsigned V_BP_DEF      = 20;
    localparam int unsigned CNT_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic int unsigned total_count(input int unsigned active,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/stream_to_video_if.sv
// Pixel-stream input handshake plus raster video outputs of stream_to_video.
// The slave modport is the converter, the master modport its environment.
interface stream_to_video_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic                  EN;
    logic [DATA_WIDTH-1:0] dIn;
    logic                  dInValid;
    logic                  nextDin;
    logic                  start;
    logic                  hs;
    logic                  vs;
    logic                  de;
    logic [DATA_WIDTH-1:0] data;
    logic                  underflow;

    modport master (
        output EN, dIn, dInValid,
        input  nextDin, start, hs, vs, de, data, underflow
    );

    modport slave (
        input  EN, dIn, dInValid,
        output nextDin, start, hs, vs, de, data, underflow
    );
endinterface

// File: rtl/stream_to_video_sync_fifo_fwft.sv
// Single-clock pixel FIFO with synchronous flush. Read data is registered and
// returns to zero on any cycle without a read.
module sync_fifo_fwft #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          wr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flush wins over both ports so a flush always leaves the FIFO empty.
    assign wr_ok     = wr_i && !full_o && !flush_i;
    assign rd_ok     = rd_i && !empty_o && !flush_i;
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == (AW + 1)'(FIFO_DEPTH));
    assign empty_o   = (count_o == '0);
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            rd_data_q <= rd_ok ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        end
    end
endmodule

// File: rtl/stream_to_video.sv
// Re-times a valid-qualified pixel stream onto a free-running hs/vs/de raster,
// restarting the upstream source once per frame via the start pulse.
module stream_to_video
    import stream_to_video_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input logic              clk,
    input logic              Reset,
    stream_to_video_if.slave vif
);
    localparam int unsigned H_TOTAL = total_count(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = total_count(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);

    localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] H_ACT  = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] HS_BEG = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] HS_END = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] V_ACT  = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] VS_BEG = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] VS_END = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_WIDTH-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_WIDTH-1:0]  v_cnt_q, v_cnt_d;
    state_t                state_q;
    logic                  hs_q, vs_q, de_q;
    logic                  underflow_q, underflow_d;

    logic                  raw_de, raw_hs, raw_vs;
    logic                  frame_start, start_w, eof_flush, run_now;
    logic                  fifo_wr, fifo_rd, fifo_flush;
    logic                  fifo_full, fifo_empty;
    logic [AW:0]           fifo_level_unused;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    assign raw_de      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign raw_hs      = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign raw_vs      = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    // First clock of vertical back porch: upstream gets V_BP lines to prefill.
    assign start_w     = vif.EN && (h_cnt_q == '0) && (v_cnt_q == VS_END);
    assign eof_flush   = (state_q == ST_RUN) && frame_start && !vif.EN;

    // The frame-boundary cycle already belongs to the frame being entered, so
    // its read follows the state being switched into rather than state_q.
    assign run_now     = frame_start ? (vif.EN && (state_q != ST_IDLE))
                                     : (state_q == ST_RUN);

    assign fifo_rd     = run_now && raw_de && !fifo_empty;
    assign fifo_wr     = vif.dInValid && vif.nextDin;
    assign fifo_flush  = start_w || eof_flush;
    assign underflow_d = underflow_q || (run_now && raw_de && fifo_empty);

    sync_fifo_fwft #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (Reset),
        .flush_i  (fifo_flush),
        .wr_i     (fifo_wr),
        .wr_data_i(vif.dIn),
        .rd_i     (fifo_rd),
        .rd_data_o(fifo_rd_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_level_unused)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hs_q        <= raw_hs;
            vs_q        <= raw_vs;
            de_q        <= raw_de;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_w) state_q <= ST_PRIME;
                ST_PRIME: if (frame_start) state_q <= vif.EN ? ST_RUN : ST_IDLE;
                ST_RUN:   if (frame_start && !vif.EN) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign vif.nextDin   = !fifo_full && (state_q != ST_IDLE);
    assign vif.start     = start_w;
    assign vif.hs        = hs_q;
    assign vif.vs        = vs_q;
    assign vif.de        = de_q;
    assign vif.data      = fifo_rd_data;
    assign vif.underflow = underflow_q;
endmodule
